// File: rtl/dds_nco_bank.sv
// Multi-channel DDS/NCO bank: per-channel shadowed FTW/phase offset with atomic commit,
// 3-stage acc -> addr -> sine LUT pipeline. Define DDS_AM_MIX_EN to add the ch0*ch1 AM stage.
module dds_nco_bank #(
  parameter int                 CH      = 3,
  parameter int                 PHASE_W = 32,
  parameter int                 LUT_AW  = 8,
  parameter int                 OUT_W   = 8,
  parameter logic [PHASE_W-1:0] DEF_FTW = 32'd42949673,
  localparam int                CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [1:0]            cfg_sel,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [PHASE_W-1:0]    cfg_data,
  output logic [CH*OUT_W-1:0]   wave_out,
  output logic                  out_valid
`ifdef DDS_AM_MIX_EN
  ,
  output logic [OUT_W-1:0]      am_out,
  output logic                  am_valid
`endif
);

  localparam int        LUT_N      = 2 ** LUT_AW;
  localparam int        HALF       = 2 ** (OUT_W - 1);
  localparam logic [1:0] SEL_FTW    = 2'd0;
  localparam logic [1:0] SEL_OFF    = 2'd1;
  localparam logic [1:0] SEL_COMMIT = 2'd2;
  localparam real       PI         = 3.14159265358979323846;

  // Sine table built at elaboration: range-reduced Taylor series, rounded half away from zero.
  function automatic logic [LUT_N*OUT_W-1:0] build_lut();
    logic [LUT_N*OUT_W-1:0] t;
    real x, term, s, a;
    int  r;
    t = '0;
    for (int k = 0; k < LUT_N; k++) begin
      x = 2.0 * PI * real'(k) / real'(LUT_N);
      if (x > PI) x = x - 2.0 * PI;
      term = x;
      s    = x;
      for (int n = 1; n < 14; n++) begin
        term = -term * x * x / real'((2 * n) * (2 * n + 1));
        s    = s + term;
      end
      a = real'(HALF - 1) * s;
      r = (a >= 0.0) ? $rtoi(a + 0.5) : $rtoi(a - 0.5);
      t[k*OUT_W +: OUT_W] = OUT_W'(HALF + r);
    end
    return t;
  endfunction

  localparam logic [LUT_N*OUT_W-1:0] LUT_FLAT = build_lut();

  // Config handshake: a write is taken on any cycle with cfg_valid && cfg_ready; cfg_ready
  // is then low for exactly the following cycle, so the port accepts at most one write per two cycles.
  logic                 cfg_ready_q, cfg_ready_d;
  logic [PHASE_W-1:0]   ftw_sh_q  [CH];
  logic [PHASE_W-1:0]   ftw_sh_d  [CH];
  logic [PHASE_W-1:0]   off_sh_q  [CH];
  logic [PHASE_W-1:0]   off_sh_d  [CH];
  logic [PHASE_W-1:0]   ftw_act_q [CH];
  logic [PHASE_W-1:0]   ftw_act_d [CH];
  logic [PHASE_W-1:0]   off_act_q [CH];
  logic [PHASE_W-1:0]   off_act_d [CH];
  logic [PHASE_W-1:0]   acc_q     [CH];
  logic [PHASE_W-1:0]   acc_d     [CH];
  logic [PHASE_W-1:0]   phase     [CH];
  logic [LUT_AW-1:0]    addr_q    [CH];
  logic [LUT_AW-1:0]    addr_d    [CH];
  logic [OUT_W-1:0]     samp_q    [CH];
  logic [OUT_W-1:0]     samp_d    [CH];
  logic [OUT_W-1:0]     wave_q    [CH];
  logic [OUT_W-1:0]     wave_d    [CH];
  logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic                 accept, do_commit, do_clear;

  always_comb begin
    accept      = cfg_valid && cfg_ready_q;
    do_commit   = accept && (cfg_sel == SEL_COMMIT);
    do_clear    = do_commit && cfg_data[0];
    cfg_ready_d = !accept;
    v1_d        = en;
    v2_d        = v1_q;
    v3_d        = v2_q;
    for (int k = 0; k < CH; k++) begin
      ftw_sh_d[k]  = ftw_sh_q[k];
      off_sh_d[k]  = off_sh_q[k];
      ftw_act_d[k] = ftw_act_q[k];
      off_act_d[k] = off_act_q[k];
      acc_d[k]     = acc_q[k];
      addr_d[k]    = addr_q[k];
      samp_d[k]    = samp_q[k];
      wave_d[k]    = wave_q[k];
      phase[k]     = acc_q[k] + off_act_q[k];

      // Channel numbers at or above CH match no k, so such writes fall through harmlessly.
      if (accept && (cfg_ch == CH_W'(k))) begin
        if (cfg_sel == SEL_FTW) ftw_sh_d[k] = cfg_data;
        if (cfg_sel == SEL_OFF) off_sh_d[k] = cfg_data;
      end
      if (do_commit) begin
        ftw_act_d[k] = ftw_sh_q[k];
        off_act_d[k] = off_sh_q[k];
      end
      // The commit edge still advances with the old FTW; a clear overrides it.
      if (do_clear)  acc_d[k] = '0;
      else if (en)   acc_d[k] = acc_q[k] + ftw_act_q[k];

      if (en)   addr_d[k] = LUT_AW'(phase[k] >> (PHASE_W - LUT_AW));
      if (v1_q) samp_d[k] = LUT_FLAT[addr_q[k]*OUT_W +: OUT_W];
      if (v2_q) wave_d[k] = samp_q[k];
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cfg_ready_q <= 1'b1;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      for (int k = 0; k < CH; k++) begin
        ftw_sh_q[k]  <= DEF_FTW;
        off_sh_q[k]  <= '0;
        ftw_act_q[k] <= DEF_FTW;
        off_act_q[k] <= '0;
        acc_q[k]     <= '0;
        addr_q[k]    <= '0;
        samp_q[k]    <= '0;
        wave_q[k]    <= '0;
      end
    end else begin
      cfg_ready_q <= cfg_ready_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      for (int k = 0; k < CH; k++) begin
        ftw_sh_q[k]  <= ftw_sh_d[k];
        off_sh_q[k]  <= off_sh_d[k];
        ftw_act_q[k] <= ftw_act_d[k];
        off_act_q[k] <= off_act_d[k];
        acc_q[k]     <= acc_d[k];
        addr_q[k]    <= addr_d[k];
        samp_q[k]    <= samp_d[k];
        wave_q[k]    <= wave_d[k];
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_pack
    assign wave_out[g*OUT_W +: OUT_W] = wave_q[g];
  end

  assign cfg_ready = cfg_ready_q;
  assign out_valid = v3_q;

`ifdef DDS_AM_MIX_EN
  localparam logic signed [OUT_W:0] HALF_S = HALF;

  logic [OUT_W-1:0]            am_q, am_d;
  logic                        am_v_q, am_v_d;
  logic signed [OUT_W:0]       ctr;
  logic signed [2*OUT_W+1:0]   prod;

  // ch0 re-centred to signed times unsigned ch1; the >>> OUT_W result always fits around mid-scale.
  always_comb begin
    am_v_d = v3_q;
    am_d   = am_q;
    ctr    = $signed({1'b0, wave_q[0]}) - HALF_S;
    prod   = ctr * $signed({1'b0, wave_q[1]});
    if (v3_q) am_d = OUT_W'(HALF) + OUT_W'(prod >>> OUT_W);
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      am_q   <= '0;
      am_v_q <= 1'b0;
    end else begin
      am_q   <= am_d;
      am_v_q <= am_v_d;
    end
  end

  assign am_out   = am_q;
  assign am_valid = am_v_q;
`endif

endmodule
